// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the data-side memory request controller:
// one-hot memop bit positions, transfer size codes and FSM states.
package mem_req_ctrl_pkg;

    localparam int OP_LB  = 0;
    localparam int OP_LBU = 1;
    localparam int OP_LH  = 2;
    localparam int OP_LHU = 3;
    localparam int OP_LW  = 4;
    localparam int OP_SB  = 5;
    localparam int OP_SH  = 6;
    localparam int OP_SW  = 7;
    localparam int OP_LWL = 8;
    localparam int OP_LWR = 9;
    localparam int OP_SWL = 10;
    localparam int OP_SWR = 11;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_DISCARD = 3'd4
    } state_t;

    function automatic logic is_store(input logic [OP_SWR:0] op);
        return op[OP_SB] | op[OP_SH] | op[OP_SW] | op[OP_SWL] | op[OP_SWR];
    endfunction

    function automatic logic [1:0] op_size(input logic [OP_SWR:0] op);
        if (op[OP_LB] | op[OP_LBU] | op[OP_SB])
            return SIZE_BYTE;
        else if (op[OP_LH] | op[OP_LHU] | op[OP_SH])
            return SIZE_HALF;
        else
            return SIZE_WORD;
    endfunction

    function automatic logic is_unaligned_word(input logic [OP_SWR:0] op);
        return op[OP_LWL] | op[OP_LWR] | op[OP_SWL] | op[OP_SWR];
    endfunction

endpackage

// File: rtl/st_lane_gen.sv
// Store lane generator: byte strobes and lane-aligned write data for
// sb/sh/sw/swl/swr. Loads produce no strobes.
module st_lane_gen
    import mem_req_ctrl_pkg::*;
#(
    parameter int MMOP_W = 12
) (
    input  logic [MMOP_W-1:0] memop,
    input  logic [1:0]        addr_low,
    input  logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic [31:0]       lane_wdata
);

    logic [4:0] shamt_left;
    logic [4:0] shamt_right;

    assign shamt_left  = {addr_low, 3'b000};
    assign shamt_right = {2'd3 - addr_low, 3'b000};

    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        wstrb      = 4'b0000;
        lane_wdata = wdata;
        if (memop[OP_SB]) begin
            wstrb      = 4'b0001 << addr_low;
            lane_wdata = {4{wdata[7:0]}};
        end else if (memop[OP_SH]) begin
            wstrb      = 4'b0011 << {addr_low[1], 1'b0};
            lane_wdata = {2{wdata[15:0]}};
        end else if (memop[OP_SW]) begin
            wstrb      = 4'b1111;
        end else if (memop[OP_SWL]) begin
            // swl writes the high bytes of the register into the low lanes
            wstrb      = 4'b1111 >> (2'd3 - addr_low);
            lane_wdata = wdata >> shamt_right;
        end else if (memop[OP_SWR]) begin
            wstrb      = 4'b1111 << addr_low;
            lane_wdata = wdata << shamt_left;
        end
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Data-side request controller: issues one memory transaction per EX-stage
// memory instruction, stalls the pipeline until it resolves, handles flushes.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MMOP_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    input  logic [MMOP_W-1:0] ex_memop_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [31:0]       ex_wdata_i,
    input  logic              flush_i,
    input  logic              pipe_stall_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [3:0]        data_wstrb_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [31:0]       data_rdata_i,
    output logic [31:0]       rdata_o,
    output logic [1:0]        addr_low_o,
    output logic              rdata_valid_o,
    output logic              stallreq_o
);

    state_t            state;
    logic              accept;
    logic [3:0]        next_wstrb;
    logic [31:0]       next_wdata;
    logic [ADDR_W-1:0] next_addr;

    st_lane_gen #(.MMOP_W(MMOP_W)) u_st_lane_gen (
        .memop      (ex_memop_i),
        .addr_low   (ex_addr_i[1:0]),
        .wdata      (ex_wdata_i),
        .wstrb      (next_wstrb),
        .lane_wdata (next_wdata)
    );

    assign next_addr = is_unaligned_word(ex_memop_i[OP_SWR:0])
                       ? {ex_addr_i[ADDR_W-1:2], 2'b00} : ex_addr_i;

    // Gated by rst_n so the stall request is also low while reset is held.
    assign accept = rst_n && (state == ST_IDLE) && ex_valid_i
                    && (|ex_memop_i) && !flush_i;

    assign stallreq_o = accept || (state == ST_REQ) || (state == ST_WAIT)
                        || (state == ST_DISCARD);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            data_req_o    <= 1'b0;
            data_wr_o     <= 1'b0;
            data_size_o   <= SIZE_BYTE;
            data_addr_o   <= '0;
            data_wstrb_o  <= 4'b0000;
            data_wdata_o  <= '0;
            rdata_o       <= '0;
            addr_low_o    <= 2'b00;
            rdata_valid_o <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_REQ;
                        data_req_o   <= 1'b1;
                        data_wr_o    <= is_store(ex_memop_i[OP_SWR:0]);
                        data_size_o  <= op_size(ex_memop_i[OP_SWR:0]);
                        data_addr_o  <= next_addr;
                        data_wstrb_o <= next_wstrb;
                        data_wdata_o <= next_wdata;
                        addr_low_o   <= ex_addr_i[1:0];
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok_i) begin
                        data_req_o <= 1'b0;
                        if (flush_i) begin
                            // a response arriving with the flush is already absorbed
                            state <= data_data_ok_i ? ST_IDLE : ST_DISCARD;
                        end else if (data_data_ok_i) begin
                            if (data_wr_o) begin
                                state <= ST_IDLE;
                            end else begin
                                state         <= ST_DONE;
                                rdata_o       <= data_rdata_i;
                                rdata_valid_o <= 1'b1;
                            end
                        end else begin
                            state <= ST_WAIT;
                        end
                    end else if (flush_i) begin
                        data_req_o <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (flush_i) begin
                        state <= data_data_ok_i ? ST_IDLE : ST_DISCARD;
                    end else if (data_data_ok_i) begin
                        if (data_wr_o) begin
                            state <= ST_IDLE;
                        end else begin
                            state         <= ST_DONE;
                            rdata_o       <= data_rdata_i;
                            rdata_valid_o <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush_i || !pipe_stall_i) begin
                        state         <= ST_IDLE;
                        rdata_valid_o <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (data_data_ok_i)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl.
module tb_mem_req_ctrl;
    import mem_req_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic [11:0] ex_memop_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic        flush_i;
    logic        pipe_stall_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic [31:0] rdata_o;
    logic [1:0]  addr_low_o;
    logic        rdata_valid_o;
    logic        stallreq_o;

    int n_assert = 0;
    int n_fail   = 0;

    mem_req_ctrl #(.ADDR_W(32), .MMOP_W(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid_i     (ex_valid_i),
        .ex_memop_i     (ex_memop_i),
        .ex_addr_i      (ex_addr_i),
        .ex_wdata_i     (ex_wdata_i),
        .flush_i        (flush_i),
        .pipe_stall_i   (pipe_stall_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_addr_o    (data_addr_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .rdata_o        (rdata_o),
        .addr_low_o     (addr_low_o),
        .rdata_valid_o  (rdata_valid_o),
        .stallreq_o     (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction in IDLE, checks the same-cycle stall, and
    // leaves the DUT in REQ with the instruction withdrawn.
    task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wdata);
        ex_valid_i = 1'b1;
        ex_memop_i = 12'd1 << op;
        ex_addr_i  = addr;
        ex_wdata_i = wdata;
        #1;
        check("issue_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        ex_valid_i = 1'b0;
        ex_memop_i = '0;
        check("issue_req", {31'd0, data_req_o}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, data_req_o},    32'd0);
        check({tag, "_wr"},    {31'd0, data_wr_o},     32'd0);
        check({tag, "_size"},  {30'd0, data_size_o},   32'd0);
        check({tag, "_addr"},  data_addr_o,            32'd0);
        check({tag, "_wstrb"}, {28'd0, data_wstrb_o},  32'd0);
        check({tag, "_wdata"}, data_wdata_o,           32'd0);
        check({tag, "_rdata"}, rdata_o,                32'd0);
        check({tag, "_alow"},  {30'd0, addr_low_o},    32'd0);
        check({tag, "_valid"}, {31'd0, rdata_valid_o}, 32'd0);
        check({tag, "_stall"}, {31'd0, stallreq_o},    32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        ex_valid_i     = 1'b0;
        ex_memop_i     = '0;
        ex_addr_i      = '0;
        ex_wdata_i     = '0;
        flush_i        = 1'b0;
        pipe_stall_i   = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // lw with both acks in the first REQ cycle, then held in DONE
        issue(OP_LW, 32'h8000_0004, 32'h0);
        check("lw_wr",    {31'd0, data_wr_o},    32'd0);
        check("lw_size",  {30'd0, data_size_o},  32'd2);
        check("lw_addr",  data_addr_o,           32'h8000_0004);
        check("lw_wstrb", {28'd0, data_wstrb_o}, 32'h0);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'hDEAD_BEEF;
        pipe_stall_i   = 1'b1;
        #1;
        check("lw_req_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = 32'h0;
        check("lw_done_req",   {31'd0, data_req_o},    32'd0);
        check("lw_done_valid", {31'd0, rdata_valid_o}, 32'd1);
        check("lw_done_rdata", rdata_o,                32'hDEAD_BEEF);
        check("lw_done_stall", {31'd0, stallreq_o},    32'd0);
        tick();
        check("lw_hold_valid", {31'd0, rdata_valid_o}, 32'd1);
        pipe_stall_i = 1'b0;
        tick();
        check("lw_idle_valid", {31'd0, rdata_valid_o}, 32'd0);

        // sb to byte 3
        issue(OP_SB, 32'h0000_1003, 32'h1234_56AB);
        check("sb_wr",    {31'd0, data_wr_o},    32'd1);
        check("sb_size",  {30'd0, data_size_o},  32'd0);
        check("sb_addr",  data_addr_o,           32'h0000_1003);
        check("sb_wstrb", {28'd0, data_wstrb_o}, 32'h8);
        check("sb_wdata", data_wdata_o,          32'hABAB_ABAB);
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        check("sb_wait_req",   {31'd0, data_req_o}, 32'd0);
        check("sb_wait_stall", {31'd0, stallreq_o}, 32'd1);
        data_data_ok_i = 1'b1;
        tick();
        data_data_ok_i = 1'b0;
        check("sb_end_stall", {31'd0, stallreq_o},    32'd0);
        check("sb_end_valid", {31'd0, rdata_valid_o}, 32'd0);

        // swl at byte 1: aligned address, low two lanes
        issue(OP_SWL, 32'h0000_2001, 32'hAABB_CCDD);
        check("swl_addr",  data_addr_o,           32'h0000_2000);
        check("swl_size",  {30'd0, data_size_o},  32'd2);
        check("swl_wstrb", {28'd0, data_wstrb_o}, 32'h3);
        check("swl_wdata", data_wdata_o,          32'h0000_AABB);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        check("swl_end_stall", {31'd0, stallreq_o}, 32'd0);

        // swr at byte 2
        issue(OP_SWR, 32'h0000_2002, 32'h1122_3344);
        check("swr_addr",  data_addr_o,           32'h0000_2000);
        check("swr_wstrb", {28'd0, data_wstrb_o}, 32'hC);
        check("swr_wdata", data_wdata_o,          32'h3344_0000);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;

        // sh at byte 2
        issue(OP_SH, 32'h0000_2006, 32'h0000_BEEF);
        check("sh_size",  {30'd0, data_size_o},  32'd1);
        check("sh_wstrb", {28'd0, data_wstrb_o}, 32'hC);
        check("sh_wdata", data_wdata_o,          32'hBEEF_BEEF);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;

        // lh with addr_ok withheld for 5 cycles
        issue(OP_LH, 32'h0000_3002, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_req",   {31'd0, data_req_o},  32'd1);
            check("bp_addr",  data_addr_o,          32'h0000_3002);
            check("bp_size",  {30'd0, data_size_o}, 32'd1);
            check("bp_stall", {31'd0, stallreq_o},  32'd1);
            tick();
        end
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        check("bp_wait_req", {31'd0, data_req_o}, 32'd0);
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'hCAFE_0123;
        tick();
        data_data_ok_i = 1'b0;
        check("bp_valid", {31'd0, rdata_valid_o}, 32'd1);
        check("bp_rdata", rdata_o,                32'hCAFE_0123);
        check("bp_alow",  {30'd0, addr_low_o},    32'd2);
        tick();
        check("bp_idle_valid", {31'd0, rdata_valid_o}, 32'd0);

        // flush in WAIT, response two cycles later is discarded
        issue(OP_LW, 32'h0000_4000, 32'h0);
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        flush_i        = 1'b1;
        tick();
        flush_i = 1'b0;
        check("disc_stall", {31'd0, stallreq_o},    32'd1);
        check("disc_req",   {31'd0, data_req_o},    32'd0);
        tick();
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h5555_AAAA;
        #1;
        check("disc_valid", {31'd0, rdata_valid_o}, 32'd0);
        tick();
        data_data_ok_i = 1'b0;
        check("disc_end_valid", {31'd0, rdata_valid_o}, 32'd0);
        check("disc_end_stall", {31'd0, stallreq_o},    32'd0);
        issue(OP_LW, 32'h0000_4008, 32'h0);
        check("post_disc_addr", data_addr_o, 32'h0000_4008);
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h0BAD_F00D;
        pipe_stall_i   = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        check("post_disc_valid", {31'd0, rdata_valid_o}, 32'd1);
        check("post_disc_rdata", rdata_o,                32'h0BAD_F00D);

        // flush in DONE
        flush_i = 1'b1;
        tick();
        flush_i      = 1'b0;
        pipe_stall_i = 1'b0;
        check("done_flush_valid", {31'd0, rdata_valid_o}, 32'd0);

        // flush in REQ before the handshake
        issue(OP_LBU, 32'h0000_5001, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("req_flush_req",   {31'd0, data_req_o}, 32'd0);
        check("req_flush_stall", {31'd0, stallreq_o}, 32'd0);

        // flush in IDLE suppresses acceptance
        ex_valid_i = 1'b1;
        ex_memop_i = 12'h010;
        ex_addr_i  = 32'h0000_6000;
        flush_i    = 1'b1;
        #1;
        check("idle_flush_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        ex_valid_i = 1'b0;
        ex_memop_i = '0;
        flush_i    = 1'b0;
        check("idle_flush_req", {31'd0, data_req_o}, 32'd0);

        // reset pulsed in WAIT
        issue(OP_LWL, 32'h0000_7003, 32'h0);
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        check("rst_pre_stall", {31'd0, stallreq_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_wait");
        tick();
        rst_n = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = 32'h7777_7777;
        tick();
        data_data_ok_i = 1'b0;
        check("rst_after_valid", {31'd0, rdata_valid_o}, 32'd0);
        check("rst_after_rdata", rdata_o,                32'd0);
        check("rst_after_stall", {31'd0, stallreq_o},    32'd0);
        tick();
        check("rst_after_valid2", {31'd0, rdata_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
